// File: rtl/nor_stim_pkg.sv
// Shared types and helpers for the NOR gate stimulus/checker block.
// Optional first-fail capture in nor_stim_checker is enabled by NOR_STIM_FIRST_FAIL_EN.
package nor_stim_pkg;

  localparam int DEF_N_IN  = 3;
  localparam int DEF_DWELL = 100;

  // Widest vector the helper accepts; callers zero-extend narrower vectors.
  localparam int EXP_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } stim_state_t;

  // Expected NOR output for an input vector (zero padding does not change ~|).
  function automatic logic exp_nor(input logic [EXP_MAX_W-1:0] vec);
    return ~|vec;
  endfunction

endpackage

// File: rtl/nor_stim_checker_dwell_timer.sv
// Dwell counter: counts enabled cycles 0..DWELL-1 and flags the last one.
// Wraps to zero after the last cycle so the next vector starts a fresh dwell.
module dwell_timer #(
  parameter int DWELL = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign last = (cnt == LAST_VAL);

  // Count while enabled; clear on request and on the final dwell cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en) begin
      if (last)      cnt <= '0;
      else           cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nor_stim_checker.sv
// Self-checking stimulus stage for an N_IN-input NOR gate.
// Sweeps all 2^N_IN vectors, holds each for DWELL cycles, samples the gate
// output on the last dwell cycle and counts mismatches.
// Define NOR_STIM_FIRST_FAIL_EN to add capture of the first failing vector.
module nor_stim_checker
  import nor_stim_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int DWELL = DEF_DWELL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_o,
  input  logic            dut_w_i,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   mismatch_cnt,
`ifdef NOR_STIM_FIRST_FAIL_EN
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_vec,
`endif
  output logic            pass
);

  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

  stim_state_t   state;
  logic          take_start;
  logic          last;
  logic          fail;
  logic [N_IN:0] mis_nxt;

  // start is honoured only when no sweep is running.
  assign take_start = start && (state != DRIVE);

  // Sample-cycle comparison; X/Z on the gate output counts as a failure.
  always_comb begin
    fail    = 1'b0;
    mis_nxt = mismatch_cnt;
    if (dut_w_i !== exp_nor(EXP_MAX_W'(vec_o))) fail = 1'b1;
    mis_nxt = mismatch_cnt + (N_IN+1)'(fail);
  end

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (take_start),
    .en    (state == DRIVE),
    .last  (last)
  );

  // Sweep sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      vec_o        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
`ifdef NOR_STIM_FIRST_FAIL_EN
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= DRIVE;
            vec_o        <= '0;
            mismatch_cnt <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
`ifdef NOR_STIM_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
`endif
          end
        end
        DRIVE: begin
          if (last) begin
            mismatch_cnt <= mis_nxt;
`ifdef NOR_STIM_FIRST_FAIL_EN
            if (fail && !first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_vec <= vec_o;
            end
`endif
            if (vec_o != VEC_MAX) begin
              vec_o <= vec_o + 1'b1;
            end else begin
              state <= DONE;
              vec_o <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mis_nxt == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_stim_checker.sv
// Directed bench: three checker instances against a good NOR (DWELL=4),
// a stuck-at-0 gate (DWELL=2) and an OR gate (DWELL=1).
module tb_nor_stim_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic [2:0] vec_a, vec_b, vec_c;
  logic [3:0] mis_a, mis_b, mis_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic pass_a, pass_b, pass_c;
  logic w_a, w_b, w_c;
`ifdef NOR_STIM_FIRST_FAIL_EN
  logic ffv_a, ffv_b, ffv_c;
  logic [2:0] ffc_a, ffc_b, ffc_c;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Gate models in front of each checker.
  assign w_a = ~|vec_a;
  assign w_b = 1'b0;
  assign w_c = |vec_c;

  nor_stim_checker #(.N_IN(3), .DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_o(vec_a), .dut_w_i(w_a),
    .busy(busy_a), .done(done_a), .mismatch_cnt(mis_a),
`ifdef NOR_STIM_FIRST_FAIL_EN
    .first_fail_vld(ffv_a), .first_fail_vec(ffc_a),
`endif
    .pass(pass_a));

  nor_stim_checker #(.N_IN(3), .DWELL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_o(vec_b), .dut_w_i(w_b),
    .busy(busy_b), .done(done_b), .mismatch_cnt(mis_b),
`ifdef NOR_STIM_FIRST_FAIL_EN
    .first_fail_vld(ffv_b), .first_fail_vec(ffc_b),
`endif
    .pass(pass_b));

  nor_stim_checker #(.N_IN(3), .DWELL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .vec_o(vec_c), .dut_w_i(w_c),
    .busy(busy_c), .done(done_c), .mismatch_cnt(mis_c),
`ifdef NOR_STIM_FIRST_FAIL_EN
    .first_fail_vld(ffv_c), .first_fail_vec(ffc_c),
`endif
    .pass(pass_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full DWELL=4 sweep on instance A; optionally pulse start at cycle 10.
  task automatic sweep_a(input bit restart_mid);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_start_busy", 32'(busy_a), 1);
    chk("a_start_done", 32'(done_a), 0);
    chk("a_start_mis", 32'(mis_a), 0);
    for (int cyc = 0; cyc < 32; cyc++) begin
      chk("a_vec", 32'(vec_a), 32'(cyc / 4));
      chk("a_busy", 32'(busy_a), 1);
      chk("a_done_low", 32'(done_a), 0);
      start_a = restart_mid && (cyc == 10);
      tick();
      start_a = 1'b0;
    end
    chk("a_end_done", 32'(done_a), 1);
    chk("a_end_busy", 32'(busy_a), 0);
    chk("a_end_vec", 32'(vec_a), 0);
    chk("a_end_mis", 32'(mis_a), 0);
    chk("a_end_pass", 32'(pass_a), 1);
`ifdef NOR_STIM_FIRST_FAIL_EN
    chk("a_ff_vld", 32'(ffv_a), 0);
`endif
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_vec_a", 32'(vec_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_mis_a", 32'(mis_a), 0);
    chk("rst_pass_a", 32'(pass_a), 0);
    chk("rst_busy_c", 32'(busy_c), 0);
    tick(); tick();
    chk("idle_hold_busy_a", 32'(busy_a), 0);

    // 1: good NOR, DWELL=4
    sweep_a(1'b0);
    // Result holds in DONE
    tick(); tick();
    chk("a_done_hold", 32'(done_a), 1);
    chk("a_pass_hold", 32'(pass_a), 1);

    // 2: stuck-at-0, DWELL=2 -> only vector 000 fails
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      chk("b_vec", 32'(vec_b), 32'(cyc / 2));
      chk("b_mis_run", 32'(mis_b), (cyc >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("b_done", 32'(done_b), 1);
    chk("b_mis", 32'(mis_b), 1);
    chk("b_pass", 32'(pass_b), 0);
`ifdef NOR_STIM_FIRST_FAIL_EN
    chk("b_ff_vld", 32'(ffv_b), 1);
    chk("b_ff_vec", 32'(ffc_b), 0);
`endif

    // 3: OR gate, DWELL=1 -> all 8 fail, count reaches 8 without wrap
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      chk("c_vec", 32'(vec_c), 32'(cyc));
      chk("c_mis_run", 32'(mis_c), 32'(cyc));
      chk("c_busy", 32'(busy_c), 1);
      tick();
    end
    chk("c_done", 32'(done_c), 1);
    chk("c_mis", 32'(mis_c), 8);
    chk("c_pass", 32'(pass_c), 0);
`ifdef NOR_STIM_FIRST_FAIL_EN
    chk("c_ff_vld", 32'(ffv_c), 1);
    chk("c_ff_vec", 32'(ffc_c), 0);
`endif

    // 6 + 4: restart from DONE, with an ignored start at cycle 10
    sweep_a(1'b1);

    // 5: reset mid-sweep while vec_o == 5
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) tick();
    chk("a_pre_rst_vec", 32'(vec_a), 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("a_rst_vec", 32'(vec_a), 0);
    chk("a_rst_busy", 32'(busy_a), 0);
    chk("a_rst_done", 32'(done_a), 0);
    chk("a_rst_mis", 32'(mis_a), 0);
    chk("a_rst_pass", 32'(pass_a), 0);
    tick(); tick(); tick();
    chk("a_rst_idle_vec", 32'(vec_a), 0);
    chk("a_rst_idle_busy", 32'(busy_a), 0);
    sweep_a(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
